button_port: RTL and testbench
==============================

BUTTON_PORT -- requirements
Module: button_port

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a level change is accepted (legal range 1..255).
REQ-002 The block SHALL have parameter CNT_W, default 8: debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port buttons_raw, input, 4 bits: asynchronous, bouncy pushbutton levels, 1 = pressed.
REQ-006 The block SHALL have port rd_strobe, input, 1 bit: one-cycle pulse from the uP when it executes a read of the input port.
REQ-007 The block SHALL have port pushbuttons, output, 4 bits: registered input-port value presented to the uP.
REQ-008 The block SHALL have port pending, output, 1 bit: at least one unread press event is held.
REQ-009 The block SHALL have port db_state, output, 4 bits: debounced button levels, for observation.

Function
REQ-010 Each raw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-011 Each bit SHALL have an independent debounce counter cnt[i].
- On an edge where sync2[i] equals db_state[i], cnt[i] SHALL load 0.
- On an edge where they differ and cnt[i] == DEBOUNCE_CYCLES-1, db_state[i] SHALL load sync2[i] and cnt[i] SHALL load 0.
- On an edge where they differ otherwise, cnt[i] SHALL increment.
REQ-012 A raw level change held stable SHALL appear on db_state at the (DEBOUNCE_CYCLES+2)th rising edge after the change; with the default parameter this is edge 6.
REQ-013 A raw pulse or glitch whose synchronized length is shorter than DEBOUNCE_CYCLES cycles SHALL leave db_state unchanged.
REQ-014 cnt[i] SHALL never exceed DEBOUNCE_CYCLES-1; no counter wrap is permitted.
REQ-015 A press event for bit i SHALL be the db_state[i] 0->1 update; a 1->0 update (release) SHALL NOT be an event.
REQ-016 sticky[i] SHALL set on the same edge as its press event.
REQ-017 On an edge with rd_strobe=1, every sticky bit SHALL clear except bits receiving a press event on that same edge; a simultaneous press SHALL win and remain set.
REQ-018 rd_strobe with sticky == 0 SHALL have no effect; rd_strobe held high for consecutive cycles SHALL clear on each such edge.
REQ-019 A repeated press of an already-set bit before a read SHALL leave that bit at 1; events are not counted.
REQ-020 pushbuttons and pending SHALL be driven from registers and SHALL have no combinational path from buttons_raw or rd_strobe.
REQ-021 pending SHALL equal the OR of all bits of pushbuttons in sticky mode.

Reset
REQ-022 On reset=0, sync1, sync2, cnt, db_state, sticky, pushbuttons and pending SHALL all go to 0 immediately, independent of clock.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count.
REQ-024 A button held through reset release SHALL be reported as a press DEBOUNCE_CYCLES+2 edges after release.

Configuration
REQ-025 With BUTTON_STICKY_EN defined, pushbuttons SHALL equal sticky and pending SHALL equal |sticky.
REQ-026 With BUTTON_STICKY_EN undefined:
- pushbuttons SHALL equal db_state;
- pending SHALL be constant 0;
- rd_strobe SHALL be ignored;
- no sticky storage SHALL be built.

Verification
REQ-027 With DEBOUNCE_CYCLES=4 and sticky mode, the bench SHALL check: buttons_raw 0000->0010 held -> db_state=0010 at edge 6, pushbuttons=0010 and pending=1 at edge 6.
REQ-028 The bench SHALL check: bit0 high for 3 cycles then low -> db_state, pushbuttons and pending remain 0000/0 throughout.
REQ-029 The bench SHALL check: pushbuttons=0011, then rd_strobe pulse -> next edge pushbuttons=0000 and pending=0; release of the buttons causes no new event.
REQ-030 The bench SHALL check: bit2 press event on the same edge as rd_strobe with sticky=0001 -> pushbuttons=0100 after that edge.
REQ-031 The bench SHALL check: reset=0 asserted at cnt=2 with raw bit3 high and held -> all outputs 0 asynchronously; after reset release, pushbuttons=1000 at release edge 6.
REQ-032 The bench SHALL check, with BUTTON_STICKY_EN undefined: press then release bit1 -> pushbuttons follows db_state (0010 then 0000), pending stays 0, rd_strobe has no effect.

Source files
------------

// File: rtl/button_port.sv
// Four-bit pushbutton input port: synchronize, debounce, optional sticky press latch.
// Define BUTTON_STICKY_EN to latch press events until the uP reads the port.
module button_port #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons_raw,
  input  logic       rd_strobe,
  output logic [3:0] pushbuttons,
  output logic       pending,
  output logic [3:0] db_state
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [CNT_W-1:0] cnt      [4];
  logic [CNT_W-1:0] cnt_next [4];
  logic [3:0]       db_next;

  always_comb begin
    db_next = db_state;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != db_state[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      db_state <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= buttons_raw;
      sync2    <= sync1;
      db_state <= db_next;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef BUTTON_STICKY_EN
  logic [3:0] sticky;
  logic [3:0] press;
  logic [3:0] sticky_next;
  logic       pend_q;

  // a press landing on the read edge survives the clear
  assign press       = db_next & ~db_state;
  assign sticky_next = (rd_strobe ? 4'b0000 : sticky) | press;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky <= '0;
      pend_q <= 1'b0;
    end else begin
      sticky <= sticky_next;
      pend_q <= |sticky_next;
    end
  end

  assign pushbuttons = sticky;
  assign pending     = pend_q;
`else
  logic unused_rd;

  assign unused_rd   = rd_strobe;
  assign pushbuttons = db_state;
  assign pending     = 1'b0;
`endif

endmodule

// File: tb/tb_button_port.sv
// Directed bench for button_port; expectations adapt to BUTTON_STICKY_EN.
module tb_button_port;

`ifdef BUTTON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] buttons_raw = 4'b0000;
  logic       rd_strobe = 1'b0;
  logic [3:0] pushbuttons;
  logic       pending;
  logic [3:0] db_state;

  int n_cmp = 0;
  int n_err = 0;

  button_port dut (
    .clock       (clock),
    .reset       (reset),
    .buttons_raw (buttons_raw),
    .rd_strobe   (rd_strobe),
    .pushbuttons (pushbuttons),
    .pending     (pending),
    .db_state    (db_state)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag,
                       input logic [3:0] obs,
                       input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [3:0] db,
                           input logic [3:0] pb,
                           input logic       pd);
    check({tag, ".db"}, db_state, db);
    check({tag, ".pb"}, pushbuttons, pb);
    check({tag, ".pend"}, {3'b000, pending}, {3'b000, pd});
  endtask

  initial begin
    // reset state
    tick(3);
    check_all("reset", 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    tick(2);
    check_all("idle", 4'b0000, 4'b0000, 1'b0);

    // 3-cycle glitch on bit0 must be rejected
    buttons_raw = 4'b0001;
    tick(3);
    buttons_raw = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      check_all("glitch", 4'b0000, 4'b0000, 1'b0);
      tick(1);
    end

    // bit1 press accepted exactly at edge 6
    buttons_raw = 4'b0010;
    tick(5);
    check_all("press1.e5", 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("press1.e6", 4'b0010, 4'b0010, STICKY);

    // add bit0, then read clears, then release yields nothing
    buttons_raw = 4'b0011;
    tick(6);
    check_all("press0.e6", 4'b0011, 4'b0011, STICKY);
    rd_strobe = 1'b1;
    tick(1);
    rd_strobe = 1'b0;
    check_all("read",
              4'b0011, STICKY ? 4'b0000 : 4'b0011, 1'b0);
    buttons_raw = 4'b0000;
    tick(8);
    check_all("release", 4'b0000, 4'b0000, 1'b0);
    rd_strobe = 1'b1;
    tick(1);
    rd_strobe = 1'b0;
    check_all("read.idle", 4'b0000, 4'b0000, 1'b0);

    // bit2 press coincides with read while bit0 is sticky
    buttons_raw = 4'b0001;
    tick(6);
    check_all("press0b", 4'b0001, 4'b0001, STICKY);
    buttons_raw = 4'b0101;
    tick(5);
    check_all("press2.e5", 4'b0001, 4'b0001, STICKY);
    rd_strobe = 1'b1;
    tick(1);
    check_all("press2.rd",
              4'b0101, STICKY ? 4'b0100 : 4'b0101, STICKY);
    tick(1);
    check_all("rd.hold1",
              4'b0101, STICKY ? 4'b0000 : 4'b0101, 1'b0);
    tick(1);
    rd_strobe = 1'b0;
    check_all("rd.hold2",
              4'b0101, STICKY ? 4'b0000 : 4'b0101, 1'b0);

    // repeated press before read keeps bit set
    buttons_raw = 4'b0100;
    tick(6);
    buttons_raw = 4'b0101;
    tick(6);
    check_all("repress", 4'b0101, STICKY ? 4'b0001 : 4'b0101, STICKY);
    buttons_raw = 4'b0100;
    tick(6);
    buttons_raw = 4'b0101;
    tick(6);
    check_all("repress2", 4'b0101, STICKY ? 4'b0001 : 4'b0101, STICKY);

    // async reset mid-debounce of bit3, held through release
    buttons_raw = 4'b1000;
    tick(4);
    #2;
    reset = 1'b0;
    #1;
    check_all("async.rst", 4'b0000, 4'b0000, 1'b0);
    tick(3);
    check_all("rst.hold", 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    tick(5);
    check_all("rel.e5", 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("rel.e6", 4'b1000, 4'b1000, STICKY);

    // release of bit3 with no read
    buttons_raw = 4'b0000;
    tick(6);
    check_all("rel3", 4'b0000, STICKY ? 4'b1000 : 4'b0000, STICKY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
